// File: rtl/i2c_cmd_arbiter.sv
// rtl/i2c_cmd_arbiter.sv - round-robin arbiter sharing one I2C_Controller among NREQ requesters
// One transfer at a time, per-owner done/error pulse, watchdog abort when END never completes.
module i2c_cmd_arbiter #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 1023,
    parameter int TW          = 10
) (
    input  logic                 clk_i2c,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_i,
    input  logic [24*NREQ-1:0]   req_data_i,
    output logic [NREQ-1:0]      grant_o,
    output logic [NREQ-1:0]      done_o,
    output logic                 err_o,
    output logic                 busy_o,
    output logic [23:0]          i2c_data_o,
    output logic                 i2c_go_o,
    input  logic                 i2c_end_i,
    input  logic [2:0]           i2c_ack_i
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_LO,
        S_WAIT_HI,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            go_q, go_d;
    logic [23:0]     data_q, data_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            end_q, end_d;
    logic            nack_q, nack_d;
    logic [IW-1:0]   pick;
    logic            found;
    logic            tmo_hit;

    // END and ACK are registered together so the NACK sample always matches the END edge seen
    assign end_d   = i2c_end_i;
    assign nack_d  = |i2c_ack_i;
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        int j;
        found = 1'b0;
        pick  = rr_q;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(rr_q) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_i[j]) begin
                found = 1'b1;
                pick  = IW'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = 1'b0;
        go_d    = go_q;
        data_d  = data_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d = pick;
                    grant_d = NREQ'(1) << pick;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                data_d  = req_data_i[int'(owner_q)*24 +: 24];
                go_d    = 1'b1;
                tmo_d   = '0;
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                tmo_d = tmo_q + TW'(1);
                if (tmo_hit) begin
                    go_d    = 1'b0;
                    done_d  = grant_q;
                    err_d   = 1'b1;
                    grant_d = '0;
                    state_d = S_DONE;
                end else if (!end_q) begin
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                tmo_d = tmo_q + TW'(1);
                // a genuine completion on the last watchdog cycle still reports its own ACK
                if (end_q || tmo_hit) begin
                    go_d    = 1'b0;
                    done_d  = grant_q;
                    err_d   = end_q ? nack_q : 1'b1;
                    grant_d = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                rr_d    = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i2c or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            go_q    <= 1'b0;
            data_q  <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            tmo_q   <= '0;
            end_q   <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            go_q    <= go_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            tmo_q   <= tmo_d;
            end_q   <= end_d;
            nack_q  <= nack_d;
        end
    end

    assign grant_o    = grant_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign busy_o     = (state_q != S_IDLE);
    assign i2c_data_o = data_q;
    assign i2c_go_o   = go_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb/tb_i2c_cmd_arbiter.sv - directed and randomized bench for i2c_cmd_arbiter
module tb_i2c_cmd_arbiter;
    localparam int NREQ = 3;
    localparam int TCYC = 1023;

    logic                clk_i2c = 1'b0;
    logic                reset_n;
    logic [NREQ-1:0]     req;
    logic [24*NREQ-1:0]  req_data;
    logic [NREQ-1:0]     grant_o, done_o;
    logic                err_o, busy_o, i2c_go_o;
    logic [23:0]         i2c_data_o;
    logic                end_i;
    logic [2:0]          ack;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    int              x_wg, x_lat;
    logic [NREQ-1:0] x_grant, x_done;
    logic [23:0]     x_data, x_ddata;
    logic            x_err, x_go;

    i2c_cmd_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TCYC), .TW(10)) dut (
        .clk_i2c    (clk_i2c),
        .reset_n    (reset_n),
        .req_i      (req),
        .req_data_i (req_data),
        .grant_o    (grant_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .busy_o     (busy_o),
        .i2c_data_o (i2c_data_o),
        .i2c_go_o   (i2c_go_o),
        .i2c_end_i  (end_i),
        .i2c_ack_i  (ack)
    );

    always #5 clk_i2c = ~clk_i2c;

    always @(negedge clk_i2c) begin
        if (reset_n === 1'b1) begin
            if (!$onehot0(grant_o) || !$onehot0(done_o) || (err_o && done_o == '0)) viol++;
        end
    end

    task automatic tick();
        @(posedge clk_i2c);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // emulates the I2C_Controller for one transfer: END falls lo cycles after GO, rises hi later
    task automatic xfer(input int lo, input int hi, input logic [2:0] ackv, input bit drop, input bit chg);
        int n;
        n = 0;
        while (!i2c_go_o && n < 40) begin
            tick();
            n++;
        end
        x_wg    = n;
        x_grant = grant_o;
        x_data  = i2c_data_o;
        if (drop) req = req & ~grant_o;
        if (chg) req_data = ~req_data;
        repeat (lo) tick();
        end_i = 1'b0;
        ack   = 3'b000;
        repeat (hi) tick();
        end_i = 1'b1;
        ack   = ackv;
        n = 0;
        do begin
            tick();
            n++;
        end while (done_o == '0 && n < 30);
        x_lat   = n;
        x_done  = done_o;
        x_err   = err_o;
        x_go    = i2c_go_o;
        x_ddata = i2c_data_o;
    endtask

    initial begin
        int n;
        int ptr;
        int e;
        int rem [NREQ];
        logic [23:0] dat [NREQ];
        logic [2:0]  av;
        bit first;

        reset_n  = 1'b0;
        req      = '0;
        req_data = '0;
        end_i    = 1'b1;
        ack      = 3'b000;
        repeat (3) tick();
        chk("rst_grant", grant_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err_busy_go", {err_o, busy_o, i2c_go_o}, 0);
        chk("rst_data", i2c_data_o, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // single request, owner 0
        req_data[23:0] = 24'h340C00;
        req = 3'b001;
        tick();
        chk("single_go_1cyc", i2c_go_o, 0);
        xfer(3, 30, 3'b000, 1'b0, 1'b0);
        chk("single_go_lat", x_wg, 1);
        chk("single_grant", x_grant, 3'b001);
        chk("single_data", x_data, 24'h340C00);
        chk("single_done_lat", x_lat, 2);
        chk("single_done", x_done, 3'b001);
        chk("single_err", x_err, 0);
        chk("single_go_drop", x_go, 0);
        req = '0;
        tick();
        chk("single_busy_after", busy_o, 0);
        tick();

        // NACK on owner 1 (drops its request mid-transfer), then a clean transfer on owner 0
        req_data[47:24] = 24'h1A2B3C;
        req = 3'b010;
        xfer(2, 5, 3'b010, 1'b1, 1'b0);
        chk("nack_grant", x_grant, 3'b010);
        chk("nack_data", x_data, 24'h1A2B3C);
        chk("nack_done", x_done, 3'b010);
        chk("nack_err", x_err, 1);
        tick();
        req_data[23:0] = 24'h345E7F;
        req = 3'b001;
        xfer(2, 4, 3'b000, 1'b0, 1'b0);
        chk("post_nack_done", x_done, 3'b001);
        chk("post_nack_err", x_err, 0);
        chk("post_nack_data", x_ddata, 24'h345E7F);
        req = '0;
        repeat (2) tick();

        // watchdog: END never falls
        req = 3'b001;
        n = 0;
        while (!i2c_go_o && n < 40) begin
            tick();
            n++;
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (done_o == '0 && n < TCYC + 20);
        chk("tmo_cycles", n, TCYC);
        chk("tmo_done", done_o, 3'b001);
        chk("tmo_err", err_o, 1);
        chk("tmo_go", i2c_go_o, 0);
        req = '0;
        chk("tmo_busy_at_done", busy_o, 1);
        tick();
        chk("tmo_busy_after", busy_o, 0);
        tick();

        // request data altered after LOAD must not reach the controller
        req_data[71:48] = 24'hABCDEF;
        req = 3'b100;
        xfer(2, 6, 3'b000, 1'b0, 1'b1);
        chk("dchg_grant", x_grant, 3'b100);
        chk("dchg_data_go", x_data, 24'hABCDEF);
        chk("dchg_data_done", x_ddata, 24'hABCDEF);
        chk("dchg_done", x_done, 3'b100);
        req = '0;
        repeat (2) tick();

        // reset in WAIT_HI
        req = 3'b010;
        n = 0;
        while (!i2c_go_o && n < 40) begin
            tick();
            n++;
        end
        chk("rstmid_go_before", i2c_go_o, 1);
        tick();
        end_i = 1'b0;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk("rstmid_outputs", {grant_o, busy_o, i2c_go_o}, 0);
        req   = '0;
        end_i = 1'b1;
        tick();
        chk("rstmid_done_in_rst", done_o, 0);
        reset_n = 1'b1;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done_o != '0) n++;
        end
        chk("rstmid_no_done", n, 0);

        // contention: 0 and 1 both held, two transfers each
        req_data[23:0]  = 24'h111111;
        req_data[47:24] = 24'h222222;
        req = 3'b011;
        for (int t = 0; t < 4; t++) begin
            xfer(1 + t, 3, 3'b000, 1'b0, 1'b0);
            chk("cont_grant", x_grant, (t % 2 == 0) ? 3'b001 : 3'b010);
            chk("cont_done", x_done, x_grant);
            chk("cont_gap", x_wg, (t == 0) ? 2 : 3);
            if (t == 2) req = req & 3'b110;
            if (t == 3) req = '0;
        end
        repeat (2) tick();

        // randomized traffic against a round-robin reference model
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        ptr = 0;
        for (int round = 0; round < 3; round++) begin
            n = 0;
            for (int k = 0; k < NREQ; k++) begin
                rem[k] = $urandom_range(0, 3);
                dat[k] = 24'($urandom());
                req_data[24*k +: 24] = dat[k];
                n += rem[k];
            end
            if (n == 0) rem[0] = 1;
            for (int k = 0; k < NREQ; k++) req[k] = (rem[k] > 0);
            first = 1'b1;
            while (rem[0] + rem[1] + rem[2] > 0) begin
                e = -1;
                for (int i = 0; i < NREQ; i++) begin
                    if (e < 0 && rem[(ptr + i) % NREQ] > 0) e = (ptr + i) % NREQ;
                end
                av = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                xfer($urandom_range(1, 5), $urandom_range(2, 12), av,
                     (rem[e] == 1) && ($urandom_range(0, 1) == 1), 1'b0);
                chk("rnd_grant", x_grant, 1 << e);
                chk("rnd_data", x_data, dat[e]);
                chk("rnd_done", x_done, 1 << e);
                chk("rnd_err", x_err, (av != 3'b000));
                chk("rnd_lat", x_lat, 2);
                chk("rnd_gap", x_wg, first ? 2 : 3);
                first  = 1'b0;
                rem[e] = rem[e] - 1;
                ptr    = (e + 1) % NREQ;
                if (rem[e] == 0) begin
                    req[e] = 1'b0;
                end else begin
                    dat[e] = 24'($urandom());
                    req_data[24*e +: 24] = dat[e];
                end
            end
            repeat (3) tick();
        end

        chk("onehot_monitor", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
